// File: rtl/systolic_edge_feeder_pkg.sv
// Shared constants and types for the systolic edge feeder and its tile buffer.
package systolic_edge_feeder_pkg;

   localparam int FP_W = 32;
   localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h00000000;

   // LOAD collects a tile word by word; STREAM replays it as skewed slices.
   typedef enum logic {
      LOAD,
      STREAM
   } state_e;

   // Counter width able to index 0..n-1, never narrower than one bit.
   function automatic int cntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/systolic_edge_feeder_tile_buffer.sv
// N x N word store: one write port, N combinational read ports (one per row).
module systolic_edge_feeder_tile_buffer
   import systolic_edge_feeder_pkg::*;
#(
   parameter int N = 4,
   parameter int W = FP_W,
   localparam int CW = cntWidth(N)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [CW-1:0] wrRow_i,
   input  logic [CW-1:0] wrCol_i,
   input  logic [W-1:0]  wrData_i,
   input  logic [CW-1:0] rdCol_i [N],
   output logic [W-1:0]  rdData_o [N]
);

   logic [W-1:0] mem_q [N][N];

   // Tile contents carry no reset: a discarded partial tile is simply overwritten.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[wrRow_i][wrCol_i] <= wrData_i;
      end
   end

   // Read port i always reads row i at the column chosen by the feeder.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         rdData_o[i] = mem_q[i][rdCol_i[i]];
      end
   end

endmodule

// File: rtl/systolic_edge_feeder.sv
// Buffers one N x N tile and replays it onto N lanes with a diagonal skew.
module systolic_edge_feeder
   import systolic_edge_feeder_pkg::*;
#(
   parameter int N = 4,
   parameter int W = FP_W
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  logic [W-1:0]   inData_i,
   input  logic           inValid_i,
   output logic           inReady_o,
   output logic [N*W-1:0] outLane_o,
   output logic           outValid_o,
   output logic           tileDone_o
);

   localparam int CW = cntWidth(N);
   // Slice counter also needs the one extra value that marks the drain cycle.
   localparam int TW = cntWidth(2 * N);

   state_e          state_q, state_d;
   logic [CW-1:0]   row_q, row_d;
   logic [CW-1:0]   col_q, col_d;
   logic [TW-1:0]   slice_q, slice_d;
   logic [N*W-1:0]  outLane_q, outLane_d;
   logic            outValid_q, outValid_d;
   logic            tileDone_q, tileDone_d;
   logic            inReady_q, inReady_d;

   logic [CW-1:0]   rdCol [N];
   logic [W-1:0]    rdData [N];
   logic [N-1:0]    laneLive;
   logic            accept;

   assign accept = inValid_i && inReady_q && (state_q == LOAD);

   systolic_edge_feeder_tile_buffer #(
      .N (N),
      .W (W)
   ) tile_buffer (
      .clk_i    (clk_i),
      .we_i     (accept),
      .wrRow_i  (row_q),
      .wrCol_i  (col_q),
      .wrData_i (inData_i),
      .rdCol_i  (rdCol),
      .rdData_o (rdData)
   );

   // Lane i shows column t-i of its row; outside 0..N-1 the lane is padding.
   always_comb begin
      int diff;
      diff = 0;
      for (int i = 0; i < N; i++) begin
         diff        = int'(slice_q) - i;
         laneLive[i] = (diff >= 0) && (diff < N);
         rdCol[i]    = laneLive[i] ? CW'(diff) : '0;
      end
   end

   // Next state: count words in LOAD, emit 2N-1 slices then one drain cycle in STREAM.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      slice_d    = slice_q;
      outLane_d  = '0;
      outValid_d = 1'b0;
      tileDone_d = 1'b0;
      inReady_d  = 1'b0;
      case (state_q)
         LOAD: begin
            inReady_d = 1'b1;
            if (accept) begin
               if (col_q == CW'(N - 1)) begin
                  col_d = '0;
                  if (row_q == CW'(N - 1)) begin
                     row_d     = '0;
                     slice_d   = '0;
                     state_d   = STREAM;
                     inReady_d = 1'b0;
                  end else begin
                     row_d = row_q + CW'(1);
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         STREAM: begin
            if (slice_q == TW'(2 * N - 1)) begin
               state_d    = LOAD;
               slice_d    = '0;
               tileDone_d = 1'b1;
               inReady_d  = 1'b1;
            end else begin
               outValid_d = 1'b1;
               slice_d    = slice_q + TW'(1);
               for (int i = 0; i < N; i++) begin
                  outLane_d[i*W +: W] = laneLive[i] ? rdData[i] : W'(FP_POS_ZERO);
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // State, counters and registered outputs; reset drops everything at once.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= LOAD;
         row_q      <= '0;
         col_q      <= '0;
         slice_q    <= '0;
         outLane_q  <= '0;
         outValid_q <= 1'b0;
         tileDone_q <= 1'b0;
         inReady_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         slice_q    <= slice_d;
         outLane_q  <= outLane_d;
         outValid_q <= outValid_d;
         tileDone_q <= tileDone_d;
         inReady_q  <= inReady_d;
      end
   end

   assign inReady_o  = inReady_q;
   assign outLane_o  = outLane_q;
   assign outValid_o = outValid_q;
   assign tileDone_o = tileDone_q;

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Self-checking bench for systolic_edge_feeder with N = 4.
module tb_systolic_edge_feeder;

   localparam int N      = 4;
   localparam int W      = 32;
   localparam int NN     = N * N;
   localparam int LW     = N * W;
   localparam int SLICES = 2 * N - 1;
   localparam int BUDGET = 400;

   typedef struct {
      int         slice;
      int         lane;
      logic [W-1:0] expWord;
   } spotVec_t;

   logic          clk;
   logic          rstN;
   logic [W-1:0]  inData;
   logic          inValid;
   logic          inReady;
   logic [LW-1:0] outLane;
   logic          outValid;
   logic          tileDone;

   int checks;
   int errors;

   logic [W-1:0]  tileA [NN];
   logic [W-1:0]  tileB [NN];
   logic [W-1:0]  tileC [NN];
   logic [LW-1:0] seen  [SLICES];
   spotVec_t      spots [12];

   systolic_edge_feeder #(
      .N (N),
      .W (W)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rstN),
      .inData_i   (inData),
      .inValid_i  (inValid),
      .inReady_o  (inReady),
      .outLane_o  (outLane),
      .outValid_o (outValid),
      .tileDone_o (tileDone)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something stalls outside the bounded loops.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Each lane's stream: i zeros, the row's N words, then zero padding.
   function automatic logic [LW-1:0] modelSlice(input logic [W-1:0] tile [NN], input int t);
      logic [LW-1:0] slice;
      logic [W-1:0]  laneQ [$];
      slice = '0;
      for (int lane = 0; lane < N; lane++) begin
         laneQ.delete();
         repeat (lane) laneQ.push_back('0);
         for (int c = 0; c < N; c++) laneQ.push_back(tile[lane*N + c]);
         while (laneQ.size() < SLICES) laneQ.push_back('0);
         slice[lane*W +: W] = laneQ[t];
      end
      return slice;
   endfunction

   // Feed one tile; mode 0 back-to-back, 1 every other cycle, else random gaps.
   task automatic applyStimulus(input logic [W-1:0] tile [NN], input int mode);
      int   idx;
      int   cyc;
      logic hs;
      idx = 0;
      cyc = 0;
      while (idx < NN && cyc < BUDGET) begin
         case (mode)
            0:       inValid = 1'b1;
            1:       inValid = (cyc % 2 == 0);
            default: inValid = 1'($urandom_range(0, 1));
         endcase
         inData = inValid ? tile[idx] : $urandom();
         hs = inValid && inReady;
         @(posedge clk); #1;
         cyc++;
         if (hs) idx++;
         checkOutput("load valid low", LW'(outValid), '0);
         checkOutput("load done low", LW'(tileDone), '0);
         checkOutput("load lanes zero", outLane, '0);
      end
      inValid = 1'b0;
      if (idx < NN) begin
         checks++;
         errors++;
         $display("[TB] FAIL load timeout actual=%0d words required=%0d", idx, NN);
      end else begin
         checkOutput("ready drops on last word", LW'(inReady), '0);
      end
   endtask

   // Watch the 2N-1 slices against the model, then the drain edge.
   task automatic streamAndCheck(input logic [W-1:0] tile [NN]);
      for (int s = 0; s < SLICES; s++) begin
         @(posedge clk); #1;
         seen[s] = outLane;
         checkOutput("stream valid high", LW'(outValid), LW'(1));
         checkOutput("stream ready low", LW'(inReady), '0);
         checkOutput("stream done low", LW'(tileDone), '0);
         checkOutput("stream slice", outLane, modelSlice(tile, s));
      end
      @(posedge clk); #1;
      checkOutput("drain valid low", LW'(outValid), '0);
      checkOutput("drain done pulse", LW'(tileDone), LW'(1));
      checkOutput("drain ready high", LW'(inReady), LW'(1));
      checkOutput("drain lanes zero", outLane, '0);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rstN    = 1'b0;
      inValid = 1'b0;
      inData  = '0;

      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            tileA[r*N + c] = {24'hA00000, 4'(r), 4'(c)};
         end
      end
      spots[0]  = '{0, 0, 32'hA0000000};
      spots[1]  = '{0, 1, 32'h00000000};
      spots[2]  = '{0, 2, 32'h00000000};
      spots[3]  = '{0, 3, 32'h00000000};
      spots[4]  = '{3, 0, 32'hA0000003};
      spots[5]  = '{3, 1, 32'hA0000012};
      spots[6]  = '{3, 2, 32'hA0000021};
      spots[7]  = '{3, 3, 32'hA0000030};
      spots[8]  = '{6, 0, 32'h00000000};
      spots[9]  = '{6, 1, 32'h00000000};
      spots[10] = '{6, 2, 32'h00000000};
      spots[11] = '{6, 3, 32'hA0000033};

      // Reset held three cycles, outputs all quiet.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset lanes", outLane, '0);
      checkOutput("reset valid", LW'(outValid), '0);
      checkOutput("reset done", LW'(tileDone), '0);
      checkOutput("reset ready", LW'(inReady), '0);
      rstN = 1'b1;
      @(posedge clk); #1;
      checkOutput("first edge ready", LW'(inReady), LW'(1));
      checkOutput("first edge valid", LW'(outValid), '0);

      // Back-to-back tile plus the spot-value table.
      $display("[TB] back-to-back tile");
      applyStimulus(tileA, 0);
      streamAndCheck(tileA);
      for (int i = 0; i < 12; i++) begin
         checkOutput($sformatf("spot t%0d lane%0d", spots[i].slice, spots[i].lane),
                     LW'(seen[spots[i].slice][spots[i].lane*W +: W]), LW'(spots[i].expWord));
      end

      // Gappy valid gives identical slices.
      $display("[TB] alternating valid");
      applyStimulus(tileA, 1);
      streamAndCheck(tileA);

      // Word held during STREAM is refused, then becomes the next tile's first word.
      $display("[TB] held valid during stream");
      applyStimulus(tileA, 0);
      inValid = 1'b1;
      inData  = 32'hDEADBEEF;
      streamAndCheck(tileA);
      tileB = tileA;
      tileB[0] = 32'hDEADBEEF;
      applyStimulus(tileB, 0);
      streamAndCheck(tileB);

      // Asynchronous reset in the middle of a stream.
      $display("[TB] reset mid-stream");
      applyStimulus(tileA, 0);
      for (int s = 0; s < 4; s++) begin
         @(posedge clk); #1;
         checkOutput("pre-abort slice", outLane, modelSlice(tileA, s));
      end
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("abort lanes", outLane, '0);
      checkOutput("abort valid", LW'(outValid), '0);
      checkOutput("abort ready", LW'(inReady), '0);
      @(posedge clk); #1;
      rstN = 1'b1;
      @(posedge clk); #1;
      checkOutput("post-abort ready", LW'(inReady), LW'(1));
      for (int i = 0; i < NN; i++) tileC[i] = $urandom();
      applyStimulus(tileC, 2);
      streamAndCheck(tileC);

      // Two tiles back-to-back, second carries a NaN at [2][1].
      $display("[TB] two tiles with NaN");
      for (int i = 0; i < NN; i++) tileB[i] = $urandom();
      for (int i = 0; i < NN; i++) tileC[i] = $urandom();
      tileC[2*N + 1] = 32'h7FC00001;
      applyStimulus(tileB, 0);
      streamAndCheck(tileB);
      applyStimulus(tileC, 0);
      streamAndCheck(tileC);
      checkOutput("nan lane2 t3", LW'(seen[3][2*W +: W]), LW'(32'h7FC00001));

      // A few random tiles with random gaps.
      $display("[TB] random tiles");
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < NN; i++) tileC[i] = $urandom();
         applyStimulus(tileC, 2);
         streamAndCheck(tileC);
      end

      @(posedge clk); #1;
      checkOutput("idle done low", LW'(tileDone), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
